// File: rtl/kf_pad_serdes.sv
// Lane-serialising pad bridge for kf_top.
// Inbound beats build data/ROM words; core results leave as beats.
module kf_pad_serdes #(
  parameter int DATA_W  = 24,
  parameter int LANE_W  = 8,
  parameter int ROM_AW  = 8,
  parameter int ROM_DW  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_in_valid,
  input  logic              pad_in_sel,
  input  logic [LANE_W-1:0] pad_in_data,
  output logic              pad_in_err,
  output logic [DATA_W-1:0] DATA_IN,
  output logic              data_valid,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_waddr,
  output logic [ROM_DW-1:0] rom_wdata,
  input  logic [DATA_W-1:0] DATA_OUT,
  input  logic              READY,
  output logic [LANE_W-1:0] pad_out_data,
  output logic              pad_out_valid,
  output logic              pad_out_last,
  output logic              pad_out_ovf
);

  localparam int RW   = ROM_AW + ROM_DW;
  localparam int BD   = DATA_W / LANE_W;
  localparam int BR   = RW / LANE_W;
  localparam int MAXB = (BD > BR) ? BD : BR;
  localparam int MAXW = MAXB * LANE_W;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW   = (BD > 1) ? $clog2(BD) : 1;
  localparam int IW   = $clog2(TIMEOUT + 1);

  if ((DATA_W % LANE_W) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of LANE_W");
  end
  if ((RW % LANE_W) != 0) begin : g_bad_rom_w
    $error("ROM_AW+ROM_DW must be a multiple of LANE_W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [MAXW-1:0] asm_q, asm_d;
  logic            sel_eff;
  logic [CW-1:0]   len_m1;
  logic            done;
  logic            done_data;
  logic            done_rom;
  logic            abort;

  // Frame type is only taken from the first beat.
  assign sel_eff = (state_q == S_IDLE) ? pad_in_sel : sel_q;
  assign len_m1  = sel_eff ? CW'(BR - 1) : CW'(BD - 1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    asm_d   = asm_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pad_in_valid) begin
          sel_d                = pad_in_sel;
          asm_d                = '0;
          asm_d[LANE_W-1:0]    = pad_in_data;
          idle_d               = '0;
          if (len_m1 == '0) begin
            done  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (pad_in_valid) begin
          asm_d[cnt_q*LANE_W +: LANE_W] = pad_in_data;
          idle_d = '0;
          if (cnt_q == len_m1) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          cnt_d   = '0;
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_data = done & ~sel_eff;
  assign done_rom  = done & sel_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      idle_q     <= '0;
      asm_q      <= '0;
      DATA_IN    <= '0;
      data_valid <= 1'b0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      pad_in_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      asm_q      <= asm_d;
      data_valid <= done_data;
      rom_we     <= done_rom;
      pad_in_err <= abort;
      if (done_data) begin
        DATA_IN <= asm_d[DATA_W-1:0];
      end
      if (done_rom) begin
        rom_waddr <= asm_d[ROM_AW-1:0];
        rom_wdata <= asm_d[RW-1:ROM_AW];
      end
    end
  end

  logic              ready_q;
  logic              tx_busy;
  logic [TW-1:0]     tx_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic              rise;
  logic              tx_last;

  assign rise    = READY & ~ready_q;
  assign tx_last = tx_busy && (tx_cnt == TW'(BD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_cnt      <= '0;
      tx_sh       <= '0;
      pad_out_ovf <= 1'b0;
    end else begin
      ready_q <= READY;
      if (tx_busy) begin
        tx_sh <= tx_sh >> LANE_W;
        if (tx_last) begin
          tx_busy <= 1'b0;
          tx_cnt  <= '0;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
        // Busy includes the last-beat cycle: the result is lost.
        if (rise) begin
          pad_out_ovf <= 1'b1;
        end
      end else if (rise) begin
        tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_sh   <= DATA_OUT;
      end
    end
  end

  assign pad_out_valid = tx_busy;
  assign pad_out_last  = tx_last;
  assign pad_out_data  = tx_busy ? tx_sh[LANE_W-1:0] : '0;

endmodule

// File: tb/tb_kf_pad_serdes.sv
// Scoreboard bench for kf_pad_serdes.
// Drivers push expected events; a negedge monitor pops and compares.
module tb_kf_pad_serdes;

  localparam int DW = 24;
  localparam int LW = 8;
  localparam int AW = 8;
  localparam int RD = 16;
  localparam int TO = 15;
  localparam int BD = DW / LW;
  localparam int BR = (AW + RD) / LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pad_in_valid = 1'b0;
  logic          pad_in_sel = 1'b0;
  logic [LW-1:0] pad_in_data = '0;
  logic          pad_in_err;
  logic [DW-1:0] DATA_IN;
  logic          data_valid;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [RD-1:0] rom_wdata;
  logic [DW-1:0] DATA_OUT = '0;
  logic          READY = 1'b0;
  logic [LW-1:0] pad_out_data;
  logic          pad_out_valid;
  logic          pad_out_last;
  logic          pad_out_ovf;

  always #5 clk = ~clk;

  kf_pad_serdes #(
    .DATA_W(DW), .LANE_W(LW), .ROM_AW(AW), .ROM_DW(RD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_in_valid(pad_in_valid), .pad_in_sel(pad_in_sel),
    .pad_in_data(pad_in_data), .pad_in_err(pad_in_err),
    .DATA_IN(DATA_IN), .data_valid(data_valid),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .DATA_OUT(DATA_OUT), .READY(READY),
    .pad_out_data(pad_out_data), .pad_out_valid(pad_out_valid),
    .pad_out_last(pad_out_last), .pad_out_ovf(pad_out_ovf)
  );

  typedef struct {
    int          cy;
    logic [31:0] val;
    logic        last;
  } exp_t;

  exp_t q_data[$];
  exp_t q_rom[$];
  exp_t q_err[$];
  exp_t q_beat[$];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] held_data = '0;
  logic [AW-1:0] held_addr = '0;
  logic [RD-1:0] held_wd = '0;
  bit ovf_flag = 1'b0;
  int ovf_at = 0;
  int tx_end = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_DATA_IN"}, DATA_IN, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_rom_we"}, rom_we, 0);
    check({tag, "_rom_waddr"}, rom_waddr, 0);
    check({tag, "_rom_wdata"}, rom_wdata, 0);
    check({tag, "_pad_in_err"}, pad_in_err, 0);
    check({tag, "_pad_out_data"}, pad_out_data, 0);
    check({tag, "_pad_out_valid"}, pad_out_valid, 0);
    check({tag, "_pad_out_last"}, pad_out_last, 0);
    check({tag, "_pad_out_ovf"}, pad_out_ovf, 0);
  endtask

  // Reference model: a frame is just a word cut into LSB-first lanes.
  task automatic send_frame(input bit sel, input logic [23:0] w,
                            input int gmin, input int gmax);
    int len;
    int g;
    len = sel ? BR : BD;
    for (int k = 0; k < len; k++) begin
      pad_in_valid = 1'b1;
      pad_in_sel   = (k == 0) ? sel : 1'($urandom);
      pad_in_data  = w[k*LW +: LW];
      step();
      if (k < len - 1) begin
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
          pad_in_valid = 1'b0;
          pad_in_data  = LW'($urandom);
          step();
        end
      end
    end
    pad_in_valid = 1'b0;
    pad_in_data  = '0;
    if (sel) q_rom.push_back('{cyc, {8'h0, w}, 1'b0});
    else q_data.push_back('{cyc, {8'h0, w}, 1'b0});
  endtask

  task automatic timeout_frame(input bit sel, input logic [23:0] w,
                               input int nb);
    for (int k = 0; k < nb; k++) begin
      pad_in_valid = 1'b1;
      pad_in_sel   = (k == 0) ? sel : 1'($urandom);
      pad_in_data  = w[k*LW +: LW];
      step();
    end
    repeat (TO) begin
      pad_in_valid = 1'b0;
      pad_in_data  = LW'($urandom);
      step();
    end
    pad_in_data = '0;
    q_err.push_back('{cyc, 32'h0, 1'b0});
  endtask

  // Result accepted only if the previous frame's last beat is done.
  task automatic model_rise(input logic [23:0] d);
    int e;
    e = cyc;
    if (e >= tx_end + 2) begin
      for (int k = 0; k < BD; k++)
        q_beat.push_back('{e + k, {24'h0, d[k*LW +: LW]}, k == BD - 1});
      tx_end = e + BD - 1;
    end else if (!ovf_flag) begin
      ovf_flag = 1'b1;
      ovf_at   = e;
    end
  endtask

  task automatic ready_pulse(input logic [23:0] d, input int hi,
                             input int lo);
    DATA_OUT = d;
    READY    = 1'b1;
    step();
    model_rise(d);
    DATA_OUT = DW'($urandom);
    repeat (hi - 1) step();
    READY = 1'b0;
    repeat (lo) step();
  endtask

  task automatic model_reset();
    q_data.delete();
    q_rom.delete();
    q_err.delete();
    q_beat.delete();
    held_data = '0;
    held_addr = '0;
    held_wd   = '0;
    ovf_flag  = 1'b0;
    tx_end    = -100;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (data_valid) begin
        if (q_data.size() == 0) check("data_valid_unexp", data_valid, 0);
        else begin
          e = q_data.pop_front();
          check("data_cyc", cyc, e.cy);
          check("data_val", DATA_IN, e.val[DW-1:0]);
          held_data = e.val[DW-1:0];
        end
      end
      check("data_hold", DATA_IN, held_data);
      if (rom_we) begin
        if (q_rom.size() == 0) check("rom_we_unexp", rom_we, 0);
        else begin
          e = q_rom.pop_front();
          check("rom_cyc", cyc, e.cy);
          check("rom_addr", rom_waddr, e.val[AW-1:0]);
          check("rom_data", rom_wdata, e.val[AW+RD-1:AW]);
          held_addr = e.val[AW-1:0];
          held_wd   = e.val[AW+RD-1:AW];
        end
      end
      check("rom_addr_hold", rom_waddr, held_addr);
      check("rom_data_hold", rom_wdata, held_wd);
      if (pad_in_err) begin
        if (q_err.size() == 0) check("err_unexp", pad_in_err, 0);
        else begin
          e = q_err.pop_front();
          check("err_cyc", cyc, e.cy);
        end
      end
      if (pad_out_valid) begin
        if (q_beat.size() == 0) check("beat_unexp", pad_out_valid, 0);
        else begin
          e = q_beat.pop_front();
          check("beat_cyc", cyc, e.cy);
          check("beat_data", pad_out_data, e.val[LW-1:0]);
          check("beat_last", pad_out_last, e.last);
        end
      end else begin
        check("idle_data", pad_out_data, 0);
        check("idle_last", pad_out_last, 0);
      end
      check("ovf", pad_out_ovf, (ovf_flag && cyc >= ovf_at) ? 1 : 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step();

    send_frame(1'b0, 24'h123456, 0, 0);
    send_frame(1'b1, 24'hBEEF10, 0, 0);
    repeat (2) step();
    send_frame(1'b0, 24'h0A0B0C, TO - 1, TO - 1);
    timeout_frame(1'b0, 24'hDEAD99, 2);
    send_frame(1'b0, 24'h987654, 0, 0);
    timeout_frame(1'b1, 24'h55AA33, 1);
    send_frame(1'b1, 24'h123480, 0, 2);
    send_frame(1'b0, 24'hFEDCBA, 0, 0);
    repeat (3) step();

    ready_pulse(24'hA1B2C3, 1, 3);
    ready_pulse(24'h111111, 1, 2);
    ready_pulse(24'h222222, 1, 3);
    ready_pulse(24'h333333, 1, 1);
    ready_pulse(24'h444444, 1, 6);

    DATA_OUT     = 24'h5A6B7C;
    READY        = 1'b1;
    pad_in_valid = 1'b1;
    pad_in_sel   = 1'b0;
    pad_in_data  = 8'h11;
    step();
    model_rise(24'h5A6B7C);
    pad_in_data = 8'h22;
    step();
    pad_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    DATA_OUT = 24'h0F1E2D;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    model_rise(24'h0F1E2D);
    READY    = 1'b0;
    DATA_OUT = '0;
    send_frame(1'b0, 24'h654321, 0, 0);
    repeat (4) step();

    fork
      begin
        repeat (30) begin
          bit          s;
          logic [23:0] w;
          s = 1'($urandom);
          w = 24'($urandom);
          if ($urandom_range(7, 0) == 0)
            timeout_frame(s, w, $urandom_range(2, 1));
          else if ($urandom_range(1, 0) == 0)
            send_frame(s, w, 0, TO - 1);
          else
            send_frame(s, w, 0, 2);
          repeat ($urandom_range(3, 0)) step();
        end
      end
      begin
        repeat (30)
          ready_pulse(24'($urandom), $urandom_range(3, 1),
                      $urandom_range(6, 1));
      end
    join

    repeat (10) step();
    check("drain_data", q_data.size(), 0);
    check("drain_rom", q_rom.size(), 0);
    check("drain_err", q_err.size(), 0);
    check("drain_beat", q_beat.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
